ascon_perm_seq: RTL

Multi-cycle sequencer for the ASCON permutation. It accepts a 320-bit state with a start strobe and applies 12, 8 or 6 rounds (p^a, p^b for ASCON-128a, p^b for ASCON-128), one round per cycle. It generates the round constants itself and returns the permuted state with a done pulse. It drives the round datapath from the controlling side and sits between the mode FSM (init/absorb/squeeze/finalise) and the single-round logic.

---
 rtl/ascon_pkg.sv | 37 +++
 rtl/ascon_round.sv | 48 ++++
 rtl/ascon_perm_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared types, round-constant table and helpers for the ASCON permutation sequencer.
package ascon_pkg;

    // Lane [4] holds x0 (bits 319:256) and lane [0] holds x4 (bits 63:0).
    typedef logic [4:0][63:0] ascon_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Entry r is {15-r, r}; index 0 sits in the low byte.
    localparam logic [11:0][7:0] ASCON_RC = {
        8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
        8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0
    };

    // Linear-layer rotations, index i applies to lane xi.
    localparam logic [4:0][5:0] ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
    localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

    function automatic logic [3:0] rounds_of(input logic [1:0] sel);
        logic [3:0] n;
        case (sel)
            2'd1:    n = 4'd8;
            2'd2:    n = 4'd6;
            default: n = 4'd12;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bit-sliced S-box, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] i_state,
    input  logic [7:0]   i_rc,
    output logic [319:0] o_state
);

    logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

    // Round datapath, evaluated in place on the five lanes.
    always_comb begin
        w_x0 = i_state[319:256];
        w_x1 = i_state[255:192];
        w_x2 = i_state[191:128] ^ {56'd0, i_rc};
        w_x3 = i_state[127:64];
        w_x4 = i_state[63:0];

        w_x0 = w_x0 ^ w_x4;
        w_x4 = w_x4 ^ w_x3;
        w_x2 = w_x2 ^ w_x1;
        w_t0 = ~w_x0 & w_x1;
        w_t1 = ~w_x1 & w_x2;
        w_t2 = ~w_x2 & w_x3;
        w_t3 = ~w_x3 & w_x4;
        w_t4 = ~w_x4 & w_x0;
        w_x0 = w_x0 ^ w_t1;
        w_x1 = w_x1 ^ w_t2;
        w_x2 = w_x2 ^ w_t3;
        w_x3 = w_x3 ^ w_t4;
        w_x4 = w_x4 ^ w_t0;
        w_x1 = w_x1 ^ w_x0;
        w_x0 = w_x0 ^ w_x4;
        w_x3 = w_x3 ^ w_x2;
        w_x2 = ~w_x2;

        o_state = {
            w_x0 ^ ror64(w_x0, ROT_A[0]) ^ ror64(w_x0, ROT_B[0]),
            w_x1 ^ ror64(w_x1, ROT_A[1]) ^ ror64(w_x1, ROT_B[1]),
            w_x2 ^ ror64(w_x2, ROT_A[2]) ^ ror64(w_x2, ROT_B[2]),
            w_x3 ^ ror64(w_x3, ROT_A[3]) ^ ror64(w_x3, ROT_B[3]),
            w_x4 ^ ror64(w_x4, ROT_A[4]) ^ ror64(w_x4, ROT_B[4])
        };
    end

endmodule

// File: rtl/ascon_perm_seq.sv
// Multi-cycle ASCON permutation sequencer (12/8/6 rounds).
// Define ASCON_PERM_UNROLL2_EN to chain two rounds per cycle.
module ascon_perm_seq
    import ascon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   rounds_sel,
    input  logic [319:0] state_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [319:0] state_out
);

`ifdef ASCON_PERM_UNROLL2_EN
    localparam logic [3:0] RND_STEP = 4'd2;
    localparam logic [3:0] RND_LAST = 4'd10;
`else
    localparam logic [3:0] RND_STEP = 4'd1;
    localparam logic [3:0] RND_LAST = 4'd11;
`endif

    seq_state_e   r_state, w_state_nxt;
    logic [3:0]   r_rnd, w_rnd_nxt;
    ascon_state_t r_st, w_st_nxt;
    logic [7:0]   w_rc0;
    logic [319:0] w_r0;
    logic [319:0] w_rnd_out;

    assign w_rc0 = ASCON_RC[r_rnd];

    ascon_round u_round0 (
        .i_state (r_st),
        .i_rc    (w_rc0),
        .o_state (w_r0)
    );

`ifdef ASCON_PERM_UNROLL2_EN
    logic [7:0]   w_rc1;
    logic [319:0] w_r1;

    // r_rnd is even and at most 10 here, so r_rnd+1 stays inside the table.
    assign w_rc1 = ASCON_RC[r_rnd + 4'd1];

    ascon_round u_round1 (
        .i_state (w_r0),
        .i_rc    (w_rc1),
        .o_state (w_r1)
    );

    assign w_rnd_out = w_r1;
`else
    assign w_rnd_out = w_r0;
`endif

    assign state_out = r_st;

    // Next-state, counter and status decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        w_st_nxt    = r_st;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_st_nxt    = state_in;
                    w_rnd_nxt   = 4'd12 - rounds_of(rounds_sel);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                w_st_nxt = w_rnd_out;
                // Counter holds on the final step so it never leaves 0..11.
                if (r_rnd == RND_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_rnd_nxt = r_rnd + RND_STEP;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and permutation-state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rnd   <= 4'd0;
            r_st    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
            r_st    <= w_st_nxt;
        end
    end

endmodule
